// File: rtl/serial_accumulator.sv
// Bit-serial adder feeding a recirculating accumulator tank, LSB first.
// Optional macro ACC_ROUND_EN: op=11 (ADD_ROUND) forces a carry-in of one at ROUND_POS.
module serial_accumulator #(
    parameter int unsigned WORD_BITS = 18,
    parameter int unsigned ACC_WORDS = 4,
    parameter int unsigned ROUND_POS = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d0,
    input  logic       m0,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       adder_b,
    input  logic       clr_ovf,
    output logic       acc_out,
    output logic       acc_sign,
    output logic       busy,
    output logic       done,
    output logic       ovf
);
    localparam int unsigned ACC_BITS = WORD_BITS * ACC_WORDS;
    localparam int unsigned BIT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned WORD_W   = (ACC_WORDS > 1) ? $clog2(ACC_WORDS) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(ACC_WORDS - 1);
    localparam logic [BIT_W-1:0]  ROUND_BIT  = BIT_W'(ROUND_POS % WORD_BITS);
    localparam logic [WORD_W-1:0] ROUND_WORD = WORD_W'(ROUND_POS / WORD_BITS);
`ifdef ACC_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_ADD            = 2'b00,
        OP_CLEAR_ADD      = 2'b01,
        OP_TRANSFER_CLEAR = 2'b10,
        OP_ADD_ROUND      = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_ACTIVE = 2'b10
    } state_e;

    logic [ACC_BITS-1:0] tank_q;
    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [BIT_W-1:0]    bit_q, cur_bit_c;
    logic [WORD_W-1:0]   word_q, cur_word_c;
    logic                carry_q;
    logic                last_c, round_hit_c, proc_c, first_c, done_d;
    logic                head_c, a_c, cin_c, sum_c, cout_c, tail_c, ovf_set_c;

    // Position of the bit currently at the head; d0/m0 realign the counters.
    always_comb begin
        cur_bit_c   = d0 ? '0 : bit_q;
        cur_word_c  = m0 ? '0 : word_q;
        last_c      = (cur_bit_c == LAST_BIT) && (cur_word_c == LAST_WORD);
        round_hit_c = (cur_bit_c == ROUND_BIT) && (cur_word_c == ROUND_WORD);
    end

    // Order sequencing; an early m0 while ACTIVE aborts the order unprocessed.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        proc_c  = 1'b0;
        first_c = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (m0) begin
                    proc_c  = 1'b1;
                    first_c = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (m0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    proc_c = 1'b1;
                    if (last_c) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Serial full adder and tail selection.
    always_comb begin
        head_c    = tank_q[0];
        a_c       = (op_q == OP_CLEAR_ADD) ? 1'b0 : head_c;
        cin_c     = first_c ? 1'b0 : carry_q;
        if (ROUND_EN && (op_q == OP_ADD_ROUND) && round_hit_c) begin
            cin_c = 1'b1;
        end
        sum_c     = a_c ^ adder_b ^ cin_c;
        cout_c    = (a_c & adder_b) | (a_c & cin_c) | (adder_b & cin_c);
        tail_c    = head_c;
        if (proc_c) begin
            tail_c = (op_q == OP_TRANSFER_CLEAR) ? 1'b0 : sum_c;
        end
        ovf_set_c = proc_c && last_c && (op_q != OP_TRANSFER_CLEAR)
                    && (a_c == adder_b) && (sum_c != a_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tank_q   <= '0;
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            bit_q    <= '0;
            word_q   <= '0;
            carry_q  <= 1'b0;
            acc_sign <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            tank_q  <= {tail_c, tank_q[ACC_BITS-1:1]};
            state_q <= state_d;
            op_q    <= op_d;
            carry_q <= proc_c ? cout_c : 1'b0;
            busy    <= (state_d != S_IDLE);
            done    <= done_d;
            if (cur_bit_c == LAST_BIT) begin
                bit_q  <= '0;
                word_q <= (cur_word_c == LAST_WORD) ? '0 : cur_word_c + 1'b1;
            end else begin
                bit_q  <= cur_bit_c + 1'b1;
                word_q <= cur_word_c;
            end
            if (last_c) begin
                acc_sign <= tail_c;
            end
            // Set wins over a simultaneous clear.
            if (ovf_set_c) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign acc_out = tank_q[0];

endmodule
